regfile_wb_arbiter: RTL and testbench

- Controller for the 32 x 64-bit general-purpose register file write port.
- Arbitrates write-back requests from NUM_REQ producers (e.g. ALU, LSU, MDU) onto the single write port, round-robin, with one registered write stage.
- Holds a busy-bit scoreboard of destination registers with outstanding writes. Decode uses it for RAW stalls; issue uses it for WAW stalls.

---
 rtl/regfile_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port controller.
// Round-robin arbitration of NUM_REQ write-back requesters onto the single
// write port, one registered write stage, and a busy-bit scoreboard used for
// RAW (decode) and WAW (issue) stalls.
// Optional macro WB_BYPASS_EN: adds rs1/rs2 forwarding from the write stage.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      we_o,
    output logic [ADDR_W-1:0]         waddr_o,
    output logic [DATA_W-1:0]         wdata_o,
    input  logic                      issue_valid_i,
    input  logic [ADDR_W-1:0]         issue_rd_i,
    output logic                      issue_ready_o,
    input  logic [ADDR_W-1:0]         rs1_addr_i,
    input  logic [ADDR_W-1:0]         rs2_addr_i,
    output logic                      rs1_busy_o,
`ifdef WB_BYPASS_EN
    output logic                      rs2_busy_o,
    output logic [DATA_W-1:0]         rs1_fwd_data_o,
    output logic [DATA_W-1:0]         rs2_fwd_data_o
`else
    output logic                      rs2_busy_o
`endif
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_next;
    logic              issue_fire;

    // Round-robin search starting at the pointer; first valid requester wins.
    always_comb begin
        int unsigned cand;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned off = 0; off < unsigned'(NUM_REQ); off++) begin
            cand = unsigned'(32'(rr_ptr)) + off;
            if (cand >= unsigned'(NUM_REQ)) cand = cand - unsigned'(NUM_REQ);
            if (!grant_any && req_valid_i[cand]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(cand);
            end
        end
        req_ready_o = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
        sel_addr    = req_addr_i[int'(grant_idx)*ADDR_W +: ADDR_W];
        sel_data    = req_data_i[int'(grant_idx)*DATA_W +: DATA_W];
    end

    // Pointer moves to the requester after the one just granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Registered write stage; address 0 handshakes complete without a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_o    <= 1'b0;
            waddr_o <= '0;
            wdata_o <= '0;
        end else if (grant_any) begin
            we_o    <= (sel_addr != '0);
            waddr_o <= sel_addr;
            wdata_o <= sel_data;
        end else begin
            we_o    <= 1'b0;
        end
    end

    assign issue_ready_o = ~busy[issue_rd_i];
    assign issue_fire    = issue_valid_i & issue_ready_o;

    // Scoreboard update: clear on write, then set on issue so set wins.
    always_comb begin
        busy_next = busy;
        if (we_o) busy_next[waddr_o] = 1'b0;
        if (issue_fire && (issue_rd_i != '0)) busy_next[issue_rd_i] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

`ifdef WB_BYPASS_EN
    // Source status with forwarding from the write stage.
    always_comb begin
        rs1_busy_o     = busy[rs1_addr_i];
        rs2_busy_o     = busy[rs2_addr_i];
        rs1_fwd_data_o = '0;
        rs2_fwd_data_o = '0;
        if (we_o && (waddr_o == rs1_addr_i) && (rs1_addr_i != '0)) begin
            rs1_busy_o     = 1'b0;
            rs1_fwd_data_o = wdata_o;
        end
        if (we_o && (waddr_o == rs2_addr_i) && (rs2_addr_i != '0)) begin
            rs2_busy_o     = 1'b0;
            rs2_fwd_data_o = wdata_o;
        end
    end
`else
    // Source status straight from the registered busy bits.
    always_comb begin
        rs1_busy_o = busy[rs1_addr_i];
        rs2_busy_o = busy[rs2_addr_i];
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NUM_REQ=2).
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 5;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] d0, d1;
    logic [1:0]        req_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              issue_ready;
    logic [ADDR_W-1:0] rs1_addr, rs2_addr;
    logic              rs1_busy, rs2_busy;
`ifdef WB_BYPASS_EN
    logic [DATA_W-1:0] rs1_fwd, rs2_fwd;
`endif

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_addr_i    ({a1, a0}),
        .req_data_i    ({d1, d0}),
        .req_ready_o   (req_ready),
        .we_o          (we),
        .waddr_o       (waddr),
        .wdata_o       (wdata),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_ready_o (issue_ready),
        .rs1_addr_i    (rs1_addr),
        .rs2_addr_i    (rs2_addr),
        .rs1_busy_o    (rs1_busy),
`ifdef WB_BYPASS_EN
        .rs2_busy_o    (rs2_busy),
        .rs1_fwd_data_o(rs1_fwd),
        .rs2_fwd_data_o(rs2_fwd)
`else
        .rs2_busy_o    (rs2_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        issue_valid = 1'b0; issue_rd = '0; rs1_addr = 5'd5; rs2_addr = 5'd3;
        #12;
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", we); end
        n_cmp++; if (waddr !== 5'd0) begin n_err++; $display("FAIL reset_waddr: got %0d want 0", waddr); end
        n_cmp++; if (wdata !== 64'd0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", wdata); end
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", rs1_busy); end
        @(negedge clk); rst = 1'b0;
        tick();
        // set busy[5], then push a write from requester 0 so the pointer moves to 1
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0;
        req_valid = 2'b01; a0 = 5'd3; d0 = 64'h1234;
        tick();
        req_valid = '0;
        n_cmp++; if (we !== 1'b1) begin n_err++; $display("FAIL pre_reset_we: got %b want 1", we); end
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL pre_reset_busy5: got %b want 1", rs1_busy); end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL async_we: got %b want 0", we); end
        n_cmp++; if (waddr !== 5'd0) begin n_err++; $display("FAIL async_waddr: got %0d want 0", waddr); end
        n_cmp++; if (wdata !== 64'd0) begin n_err++; $display("FAIL async_wdata: got %h want 0", wdata); end
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL async_busy5: got %b want 0", rs1_busy); end
        #1 rst = 1'b0;
        req_valid = 2'b11;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL post_reset_grant: got %b want 01", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_single_write();
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sw_issue_ready: got %b want 1", issue_ready); end
        tick();
        issue_valid = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sw_busy_set: got %b want 1", rs1_busy); end
        req_valid = 2'b10; a1 = 5'd5; d1 = 64'hDEAD_BEEF;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL sw_grant: got %b want 10", req_ready); end
        tick();
        req_valid = '0;
        n_cmp++; if (we !== 1'b1) begin n_err++; $display("FAIL sw_we: got %b want 1", we); end
        n_cmp++; if (waddr !== 5'd5) begin n_err++; $display("FAIL sw_waddr: got %0d want 5", waddr); end
        n_cmp++; if (wdata !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL sw_wdata: got %h want deadbeef", wdata); end
`ifdef WB_BYPASS_EN
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL sw_busy_wcycle: got %b want 0", rs1_busy); end
        n_cmp++; if (rs1_fwd !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL sw_fwd1: got %h want deadbeef", rs1_fwd); end
        n_cmp++; if (rs2_fwd !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL sw_fwd2: got %h want deadbeef", rs2_fwd); end
`else
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sw_busy_wcycle: got %b want 1", rs1_busy); end
        n_cmp++; if (rs2_busy !== 1'b1) begin n_err++; $display("FAIL sw_busy2_wcycle: got %b want 1", rs2_busy); end
`endif
        tick();
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL sw_we_drop: got %b want 0", we); end
        n_cmp++; if (waddr !== 5'd5) begin n_err++; $display("FAIL sw_waddr_hold: got %0d want 5", waddr); end
        n_cmp++; if (wdata !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL sw_wdata_hold: got %h want deadbeef", wdata); end
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL sw_busy_clear: got %b want 0", rs1_busy); end
        n_cmp++; if (rs2_busy !== 1'b0) begin n_err++; $display("FAIL sw_busy2_clear: got %b want 0", rs2_busy); end
`ifdef WB_BYPASS_EN
        n_cmp++; if (rs1_fwd !== 64'd0) begin n_err++; $display("FAIL sw_fwd_idle: got %h want 0", rs1_fwd); end
`endif
    endtask

    task automatic test_round_robin();
        logic [1:0]        exp_g [4];
        logic [ADDR_W-1:0] exp_a [4];
        logic [DATA_W-1:0] exp_d [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_a = '{5'd10, 5'd11, 5'd10, 5'd11};
        exp_d = '{64'hA0A0, 64'hB1B1, 64'hA0A0, 64'hB1B1};
        req_valid = 2'b11; a0 = 5'd10; d0 = 64'hA0A0; a1 = 5'd11; d1 = 64'hB1B1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (req_ready !== exp_g[i]) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", i, req_ready, exp_g[i]); end
            tick();
            n_cmp++; if (we !== 1'b1 || waddr !== exp_a[i] || wdata !== exp_d[i]) begin
                n_err++; $display("FAIL rr_write[%0d]: got we=%b a=%0d d=%h want we=1 a=%0d d=%h", i, we, waddr, wdata, exp_a[i], exp_d[i]);
            end
        end
        req_valid = '0;
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rr_idle_grant: got %b want 00", req_ready); end
        tick();
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL rr_we_drop: got %b want 0", we); end
    endtask

    task automatic test_waw_stall();
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall[%0d]: got %b want 0", i, issue_ready); end
            tick();
        end
        req_valid = 2'b01; a0 = 5'd7; d0 = 64'h7777;
        tick();
        req_valid = '0;
        n_cmp++; if (we !== 1'b1 || waddr !== 5'd7) begin n_err++; $display("FAIL waw_write: got we=%b a=%0d want we=1 a=7", we, waddr); end
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall_wcycle: got %b want 0", issue_ready); end
        tick();
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL waw_release: got %b want 1", issue_ready); end
        issue_valid = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        rs1_addr = 5'd9;
        req_valid = 2'b10; a1 = 5'd9; d1 = 64'h9999;
        tick();
        req_valid = '0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        n_cmp++; if (we !== 1'b1 || issue_ready !== 1'b1) begin n_err++; $display("FAIL col_setup: got we=%b ir=%b want we=1 ir=1", we, issue_ready); end
        tick();
        issue_valid = 1'b0;
        n_cmp++; if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL col_set_wins: got %b want 1", rs1_busy); end
        n_cmp++; if (issue_ready !== 1'b0) begin n_err++; $display("FAIL col_issue_ready: got %b want 0", issue_ready); end
        req_valid = 2'b10;
        tick();
        req_valid = '0;
        tick();
        n_cmp++; if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL col_cleanup: got %b want 0", rs1_busy); end
    endtask

    task automatic test_addr0();
        issue_valid = 1'b1; issue_rd = 5'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        req_valid = 2'b01; a0 = 5'd0; d0 = 64'h5555;
        #1;
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL a0_issue_ready: got %b want 1", issue_ready); end
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL a0_grant: got %b want 01", req_ready); end
        tick();
        issue_valid = 1'b0; req_valid = '0;
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL a0_we: got %b want 0", we); end
        n_cmp++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin n_err++; $display("FAIL a0_busy: got %b%b want 00", rs1_busy, rs2_busy); end
        n_cmp++; if (issue_ready !== 1'b1) begin n_err++; $display("FAIL a0_issue_after: got %b want 1", issue_ready); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_waw_stall();
        test_collision();
        test_addr0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
